// File: rtl/vlpf_pkg.sv
// Shared definitions for the vertical low-pass filter: edge codes, the sum
// width helper and the rounding constant.
// Build option VLPF_ROUND_EN: defined gives round-half-up (R=2); undefined
// gives truncation (R=0). The filter pipeline's normal build defines it.
package vlpf_pkg;

  typedef enum logic [1:0] {
    EDGE_IDLE   = 2'd0,
    EDGE_TOP    = 2'd1,
    EDGE_CENTER = 2'd2,
    EDGE_BOTTOM = 2'd3
  } edge_e;

  // Weighted 3-tap sum of DW-bit pixels (weights total 4) needs two extra bits.
  function automatic int sumWidth(input int dw);
    return dw + 2;
  endfunction

`ifdef VLPF_ROUND_EN
  localparam int ROUND_ADD = 2;
`else
  localparam int ROUND_ADD = 0;
`endif

endpackage

// File: rtl/lpf_linebuf.sv
// One row of pixel history: simple dual-port RAM, depth 2^XB, registered read.
// A stall freezes both the read register and the write port. A read and a
// write to the same address in one cycle return the old word.
module lpf_linebuf #(
  parameter int XB = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          stall_i,
  input  logic          we_i,
  input  logic [XB-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [XB-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 1 << XB;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Registered read and write, both held while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!stall_i) begin
      rdata_q <= mem[raddr_i];
      if (we_i) begin
        mem[waddr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vertical_lpf_core.sv
// Vertical 3-tap [1 2 1]/4 low-pass filter with edge replication.
// Stage A aligns the pixel with its edge code and addresses both line
// buffers. Stage B forms the weighted sum. An output register follows.
// lb1 holds row n-1 and lb2 holds row n-2. lb2 is written one cycle late,
// in stage B, from the lb1 read data. A forwarding register covers the
// 1-pixel-wide row case, where that late write and the next read of the
// same address fall in the same cycle.
// Build option VLPF_ROUND_EN selects rounding (see vlpf_pkg).
module vertical_lpf_core
  import vlpf_pkg::*;
#(
  parameter int XB = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_pix,
  input  logic          i_pix_valid,
  input  logic [1:0]    i_type,
  input  logic          i_col1,
  input  logic          i_colN,
  input  logic          i_stall,
  output logic [DW-1:0] o_pix,
  output logic          o_valid,
  output logic          o_col1,
  output logic          o_colN
);

  localparam int SW = sumWidth(DW);

  // Stage A
  edge_e         typeA;
  logic          activeA;
  logic          wrA;
  logic [XB-1:0] colA;
  logic [XB-1:0] colCnt_q, colCnt_d;
  logic [DW-1:0] rPix_q;
  logic          rV_q;

  // Stage B
  edge_e         typeB_q;
  logic [DW-1:0] cPix_q;
  logic [XB-1:0] colB_q;
  logic          wrB_q;
  logic          col1B_q;
  logic          colNB_q;
  logic          byp_q, byp_d;
  logic [DW-1:0] bypData_q;

  logic [DW-1:0] p1;
  logic [DW-1:0] p2;
  logic [DW-1:0] lb2Rd;
  logic [SW-1:0] cExt, p1Ext, p2Ext;
  logic [SW-1:0] sum;
  logic [SW-1:0] rounded;
  logic          validB;
  logic [DW-1:0] pixB;

  // Output register
  logic [DW-1:0] oPix_q;
  logic          oValid_q;
  logic          oCol1_q;
  logic          oColN_q;

  assign typeA = edge_e'(i_type);

  // Stage A decode: effective column, counter advance, lb1 write, forwarding hit.
  always_comb begin
    activeA = (typeA != EDGE_IDLE) || rV_q;
    colA    = colCnt_q;
    if (activeA && i_col1) begin
      colA = '0;
    end
    colCnt_d = colCnt_q;
    if (activeA) begin
      colCnt_d = colA + XB'(1);
    end
    wrA   = (typeA == EDGE_TOP) || (typeA == EDGE_CENTER) ||
            ((typeA == EDGE_IDLE) && rV_q);
    byp_d = wrB_q && (colB_q == colA);
  end

  // Stage A registers: delayed pixel, delayed valid and column counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rPix_q   <= '0;
      rV_q     <= 1'b0;
      colCnt_q <= '0;
    end else if (!i_stall) begin
      rPix_q   <= i_pix;
      rV_q     <= i_pix_valid;
      colCnt_q <= colCnt_d;
    end
  end

  lpf_linebuf #(
    .XB(XB),
    .DW(DW)
  ) u_lb1 (
    .clk     (clk),
    .stall_i (i_stall),
    .we_i    (wrA),
    .waddr_i (colA),
    .wdata_i (rPix_q),
    .raddr_i (colA),
    .rdata_o (p1)
  );

  lpf_linebuf #(
    .XB(XB),
    .DW(DW)
  ) u_lb2 (
    .clk     (clk),
    .stall_i (i_stall),
    .we_i    (wrB_q),
    .waddr_i (colB_q),
    .wdata_i (p1),
    .raddr_i (colA),
    .rdata_o (lb2Rd)
  );

  assign p2 = byp_q ? bypData_q : lb2Rd;

  // Stage B registers: current pixel, edge code, flags and the pending lb2 write.
  always_ff @(posedge clk) begin
    if (rst) begin
      typeB_q   <= EDGE_IDLE;
      cPix_q    <= '0;
      colB_q    <= '0;
      wrB_q     <= 1'b0;
      col1B_q   <= 1'b0;
      colNB_q   <= 1'b0;
      byp_q     <= 1'b0;
      bypData_q <= '0;
    end else if (!i_stall) begin
      typeB_q   <= typeA;
      cPix_q    <= rPix_q;
      colB_q    <= colA;
      wrB_q     <= wrA;
      col1B_q   <= i_col1;
      colNB_q   <= i_colN;
      byp_q     <= byp_d;
      bypData_q <= p1;
    end
  end

  // Stage B arithmetic: edge-dependent weights, optional rounding, divide by 4.
  always_comb begin
    cExt  = {2'b00, cPix_q};
    p1Ext = {2'b00, p1};
    p2Ext = {2'b00, p2};
    sum   = '0;
    case (typeB_q)
      EDGE_TOP:    sum = p1Ext + p1Ext + p1Ext + cExt;
      EDGE_CENTER: sum = p2Ext + p1Ext + p1Ext + cExt;
      EDGE_BOTTOM: sum = p2Ext + p1Ext + p1Ext + p1Ext;
      default:     sum = '0;
    endcase
    validB  = (typeB_q != EDGE_IDLE);
    rounded = sum + SW'(ROUND_ADD);
    pixB    = rounded[SW-1:2];
  end

  // Output register: loads each unstalled cycle, so a stall holds o_valid as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      oPix_q   <= '0;
      oValid_q <= 1'b0;
      oCol1_q  <= 1'b0;
      oColN_q  <= 1'b0;
    end else if (!i_stall) begin
      oPix_q   <= pixB;
      oValid_q <= validB;
      oCol1_q  <= col1B_q && validB;
      oColN_q  <= colNB_q && validB;
    end
  end

  assign o_pix   = oPix_q;
  assign o_valid = oValid_q;
  assign o_col1  = oCol1_q;
  assign o_colN  = oColN_q;

endmodule

// File: tb/tb_vertical_lpf_core.sv
// Self-checking bench for vertical_lpf_core. Frames are streamed in raster
// order. Expected outputs come from hand tables or from a clamped-neighbour
// model, out[r][c] = (img[r-1][c] + 2*img[r][c] + img[r+1][c] + R) / 4,
// where row indices are clamped to the image.
module tb_vertical_lpf_core;
  import vlpf_pkg::*;

  localparam int XB = 10;
  localparam int DW = 8;
`ifdef VLPF_ROUND_EN
  localparam int RND = 2;
`else
  localparam int RND = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_pix;
  logic          i_pix_valid;
  logic [1:0]    i_type;
  logic          i_col1;
  logic          i_colN;
  logic          i_stall;
  logic [DW-1:0] o_pix;
  logic          o_valid;
  logic          o_col1;
  logic          o_colN;

  typedef struct packed {
    logic [7:0] pix;
    logic       col1;
    logic       colN;
  } exp_t;

  typedef struct packed {
    logic [2:0]      nRows;
    logic [3:0][7:0] rows;
    logic [3:0][7:0] expR;
    logic [3:0][7:0] expT;
  } vec_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         img[8][8];
  logic       edgeAdv = 1'b0;
  logic       edgeStall = 1'b0;
  logic       prevValid = 1'b0;
  logic [7:0] prevPix = '0;
  vec_t       vecs[5];

  vertical_lpf_core #(
    .XB(XB),
    .DW(DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pix       (i_pix),
    .i_pix_valid (i_pix_valid),
    .i_type      (i_type),
    .i_col1      (i_col1),
    .i_colN      (i_colN),
    .i_stall     (i_stall),
    .o_pix       (o_pix),
    .o_valid     (o_valid),
    .o_col1      (o_col1),
    .o_colN      (o_colN)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Remember whether the last edge advanced the pipeline, stalled it, or reset it.
  always @(posedge clk) begin
    edgeAdv   <= !i_stall && !rst;
    edgeStall <= i_stall && !rst;
  end

  // Output monitor: hold check after stalled edges, scoreboard compare after advancing edges.
  always @(negedge clk) begin
    exp_t e;
    if (edgeStall) begin
      checkOutput("hold_valid", int'(o_valid), int'(prevValid));
      checkOutput("hold_pix", int'(o_pix), int'(prevPix));
    end else if (edgeAdv && o_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output actual=%0d required=none", o_pix);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_pix", int'(o_pix), int'(e.pix));
        checkOutput("out_col1", int'(o_col1), int'(e.col1));
        checkOutput("out_colN", int'(o_colN), int'(e.colN));
      end
    end
    prevValid = o_valid;
    prevPix   = o_pix;
  end

  task automatic idleInputs();
    i_pix       = '0;
    i_pix_valid = 1'b0;
    i_type      = EDGE_IDLE;
    i_col1      = 1'b0;
    i_colN      = 1'b0;
    i_stall     = 1'b0;
  endtask

  // Beat k of a frame: pixel of beat k, plus the edge code and flags of beat k-1.
  task automatic driveBeat(input int w, input int n, input int k);
    int total;
    int row;
    int col;
    int pr;
    int pc;
    total = w * (n + 1);
    if (k < total) begin
      row         = k / w;
      col         = k % w;
      i_pix       = (row < n) ? 8'(img[row][col]) : 8'd0;
      i_pix_valid = (row < n);
    end else begin
      i_pix       = '0;
      i_pix_valid = 1'b0;
    end
    if (k >= 1) begin
      pr = (k - 1) / w;
      pc = (k - 1) % w;
      if (pr == 0)      i_type = EDGE_IDLE;
      else if (pr == 1) i_type = EDGE_TOP;
      else if (pr < n)  i_type = EDGE_CENTER;
      else              i_type = EDGE_BOTTOM;
      i_col1 = (pc == 0);
      i_colN = (pc == w - 1);
    end else begin
      i_type = EDGE_IDLE;
      i_col1 = 1'b0;
      i_colN = 1'b0;
    end
  endtask

  // Stream one w x n frame; optional stall at beat stallAt, optional reset at beat abortAt.
  task automatic applyStimulus(input int w, input int n, input int stallAt,
                               input int stallLen, input int abortAt);
    int beats;
    beats = w * (n + 1);
    for (int k = 0; k <= beats; k++) begin
      if (k == abortAt) begin
        idleInputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("reset_midframe_valid", int'(o_valid), 0);
        checkOutput("reset_midframe_pix", int'(o_pix), 0);
        @(posedge clk);
        #1;
        return;
      end
      driveBeat(w, n, k);
      if (k == stallAt) begin
        i_stall = 1'b1;
        repeat (stallLen) begin
          @(posedge clk);
          #1;
        end
        i_stall = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    idleInputs();
  endtask

  // Reference model: replicate edge rows, weight [1 2 1], add R, divide by 4.
  task automatic pushModel(input int w, input int n);
    int up;
    int dn;
    int s;
    exp_t e;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < w; c++) begin
        up     = img[(r == 0) ? 0 : r - 1][c];
        dn     = img[(r == n - 1) ? r : r + 1][c];
        s      = up + 2 * img[r][c] + dn;
        e.pix  = 8'((s + RND) / 4);
        e.col1 = (c == 0);
        e.colN = (c == w - 1);
        expQ.push_back(e);
      end
    end
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 60) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("drain_remaining", expQ.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fillImage(input int w, input int n, input int value, input bit randomize);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < w; c++) begin
        img[r][c] = randomize ? int'($urandom_range(0, 255)) : value;
      end
    end
  endtask

  initial begin
    exp_t e;
    int   w;
    int   n;
    int   sAt;
    int   sLen;

    // Single-column vectors: rows top to bottom and hand-computed outputs.
    vecs[0] = '{nRows: 3'd4, rows: {8'd120, 8'd80, 8'd40, 8'd0},
                expR: {8'd110, 8'd80, 8'd40, 8'd10}, expT: {8'd110, 8'd80, 8'd40, 8'd10}};
    vecs[1] = '{nRows: 3'd2, rows: {8'd0, 8'd0, 8'd2, 8'd1},
                expR: {8'd0, 8'd0, 8'd2, 8'd1}, expT: {8'd0, 8'd0, 8'd1, 8'd1}};
    vecs[2] = '{nRows: 3'd3, rows: {8'd0, 8'd2, 8'd2, 8'd1},
                expR: {8'd0, 8'd2, 8'd2, 8'd1}, expT: {8'd0, 8'd2, 8'd1, 8'd1}};
    vecs[3] = '{nRows: 3'd3, rows: {8'd0, 8'd255, 8'd255, 8'd255},
                expR: {8'd0, 8'd255, 8'd255, 8'd255}, expT: {8'd0, 8'd255, 8'd255, 8'd255}};
    vecs[4] = '{nRows: 3'd2, rows: {8'd0, 8'd0, 8'd255, 8'd0},
                expR: {8'd0, 8'd0, 8'd191, 8'd64}, expT: {8'd0, 8'd0, 8'd191, 8'd63}};

    idleInputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_pix", int'(o_pix), 0);
    checkOutput("reset_valid", int'(o_valid), 0);
    checkOutput("reset_col1", int'(o_col1), 0);
    checkOutput("reset_colN", int'(o_colN), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] 4x3 flat image of 100");
    fillImage(4, 3, 100, 1'b0);
    pushModel(4, 3);
    applyStimulus(4, 3, -1, 0, -1);
    waitDrain();

    $display("[TB] single-column table vectors");
    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < int'(vecs[v].nRows); r++) begin
        img[r][0] = int'(vecs[v].rows[r]);
`ifdef VLPF_ROUND_EN
        e.pix = vecs[v].expR[r];
`else
        e.pix = vecs[v].expT[r];
`endif
        e.col1 = 1'b1;
        e.colN = 1'b1;
        expQ.push_back(e);
      end
      applyStimulus(1, int'(vecs[v].nRows), -1, 0, -1);
      waitDrain();
    end

    $display("[TB] 4x3 flat image of 255");
    fillImage(4, 3, 255, 1'b0);
    pushModel(4, 3);
    applyStimulus(4, 3, -1, 0, -1);
    waitDrain();

    $display("[TB] 4x3 random image without and with a 3-cycle stall");
    fillImage(4, 3, 0, 1'b1);
    pushModel(4, 3);
    applyStimulus(4, 3, -1, 0, -1);
    waitDrain();
    pushModel(4, 3);
    applyStimulus(4, 3, 6, 3, -1);
    waitDrain();

    $display("[TB] random frames with random stalls");
    for (int i = 0; i < 8; i++) begin
      w    = int'($urandom_range(1, 8));
      n    = int'($urandom_range(2, 6));
      sAt  = (i % 2 == 1) ? int'($urandom_range(1, w * (n + 1))) : -1;
      sLen = int'($urandom_range(1, 3));
      fillImage(w, n, 0, 1'b1);
      pushModel(w, n);
      applyStimulus(w, n, sAt, sLen, -1);
      waitDrain();
    end

    $display("[TB] reset mid-frame then full 4x3 frame");
    fillImage(4, 3, 0, 1'b1);
    pushModel(4, 3);
    applyStimulus(4, 3, -1, 0, 7);
    pushModel(4, 3);
    applyStimulus(4, 3, -1, 0, -1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vertical_lpf_core.md
# vertical_lpf_core

Vertical 3-tap low-pass datapath for the image filter pipeline. It consumes the raster pixel stream together with the per-pixel vertical edge code from the vertical edge classifier, keeps the two previous rows in on-chip line buffers, and emits one vertically filtered pixel per input pixel. Edges are handled by replication. Its output feeds the horizontal filter stage.

## Interface
- XB, 10: column address width; max row width is 2^XB pixels.
- DW, 8: pixel width in bits.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_pix  in  DW  raw pixel, valid when i_pix_valid.
- i_pix_valid  in  1  raw pixel strobe.
- i_type  in  2  edge code (0 idle, 1 top, 2 center, 3 bottom); arrives one cycle after the matching i_pix.
- i_col1  in  1  first column flag, aligned with i_type.
- i_colN  in  1  last column flag, aligned with i_type.
- i_stall  in  1  downstream stall; freezes the whole block.
- o_pix  out  DW  filtered pixel.
- o_valid  out  1  o_pix valid.
- o_col1  out  1  first column flag, aligned with o_pix.
- o_colN  out  1  last column flag, aligned with o_pix.

## Operation
- Stage A (type stage):
  - r_pix <= i_pix, so r_pix aligns with i_type.
  - Column counter col: cleared to 0 when i_col1=1 and i_type!=0; otherwise increments on each i_type!=0 cycle. It is not wrapped by i_colN; i_colN only marks the end of the row.
- Line buffers: lb1 holds row n-1, lb2 holds row n-2. Both are read at col in stage A.
- Write rules in stage A:
  - On i_type in {1,2}: lb2[col] <= lb1[col] and lb1[col] <= r_pix (read-before-write, same address).
  - On i_type 3: no writes.
  - The first row is written while i_type=0 and i_pix_valid is delayed-valid. A delayed valid bit r_v qualifies the write. The counter advances on r_v even when type=0.
- Stage B (arithmetic) holds c = current r_pix, p1 = lb1 read, p2 = lb2 read.
  - type 1 (output row 0): sum = 3*p1 + c.
  - type 2 (output row n-1): sum = p2 + 2*p1 + c.
  - type 3 (output last row): sum = p2 + 3*p1.
  - sum is DW+2 bits wide, unsigned. o_pix = (sum + R) >> 2, where R is set under Configuration. No overflow is possible.
- o_valid=1 for types 1-3. Type 0 produces no output.
- Image of N rows gives exactly N outputs per column: N-1 during input rows 1..N-1 and one during the bottom flush.
- Reset mid-frame: counter, r_v, and pipeline valid bits clear; line buffer contents are don't-care. The next frame must start with a fresh top row.
- Single-row images (N=1) are unsupported.

## Timing
- Latency: o_pix is valid 2 cycles after its i_type cycle, which is 3 cycles after the i_pix of the newest contributing row.
- Throughput: 1 pixel/cycle.
- i_stall=1: all registers, counter, and RAM writes hold. Outputs keep their values, and o_valid is held, not dropped. Upstream holds its inputs for the same cycle.
- Line buffer RAM has a registered read, 1 cycle, aligned into stage B.
- Reset values: o_pix=0, o_valid=0, o_col1=0, o_colN=0, col=0.
- i_col1 and i_colN may both be 1 (1-pixel row): col resets to 0 and the row ends.

## Configuration
- VLPF_ROUND_EN:
  - Defined: R=2, round-half-up.
  - Undefined: R=0, truncation.
  - Default build defines it.

## Structure
- Shared package vlpf_pkg holds:
  - edge code constants EDGE_IDLE=0, EDGE_TOP=1, EDGE_CENTER=2, EDGE_BOTTOM=3;
  - the sum width function DW+2.
- Sub-module lpf_linebuf: simple dual-port RAM, depth 2^XB, width DW, registered read, write enable, stall hold. It is instantiated twice (lb1, lb2).

## Test plan
- 4x3 image, all pixels 100 -> 12 outputs of 100, o_col1 on cols 0, o_colN on cols 3, top/center/bottom order.
- 1-column image, rows 0,40,80,120 (single column, no stall) -> outputs 10, 40, 80, 110 (rounded).
- Rounding: top row 1, second row 2 -> sum 5; VLPF_ROUND_EN gives 1, without it 1; rows 1,2,2 center -> sum 7, gives 2 with rounding, 1 without.
- Max values: all 255 -> output 255, no wrap in either build.
- i_stall asserted 3 cycles mid-row -> output sequence identical to the no-stall run, o_valid held during the stall, no duplicate or lost pixels.
- rst for 1 cycle mid-frame, then full 4x3 frame -> o_valid=0 the cycle after reset, and the new frame matches the golden output exactly.
